// File: rtl/core_bus_pkg.sv
// Shared definitions for the byte-serial core bus: port FSM states,
// transfer direction encoding and the default bus address width.
package core_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } port_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEFAULT_ADDR_W = 10;

endpackage

// File: rtl/mem_word_port.sv
// Splits a word read/write into big-endian byte transfers on the shared bus.
// Latency: 2*BYTES cycles from accept to resp_valid with zero-wait grants.
// Backpressure: one transfer at a time; req_ready low until the response cycle.
module mem_word_port
  import core_bus_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [8*BYTES-1:0] req_wdata,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [8*BYTES-1:0] resp_rdata,
  output logic               grant_request,
  input  logic               grant_given,
  output logic               rw,
  output logic [ADDR_W-1:0]  address,
  output logic [7:0]         data_out,
  input  logic [7:0]         data_in
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  port_state_t        state;
  logic               wr_q;
  logic               err_q;
  logic [ADDR_W-1:0]  base_q;
  logic [8*BYTES-1:0] wdata_q;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   tcnt;

  // Byte k of a word sits at base+k, so byte 0 is the most significant.
  function automatic logic [7:0] pick_byte(input logic [8*BYTES-1:0] w,
                                           input logic [IDX_W-1:0]   i);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (i == IDX_W'(k)) b = w[8*(BYTES-1-k) +: 8];
    end
    return b;
  endfunction

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      wr_q          <= RW_READ;
      err_q         <= 1'b0;
      base_q        <= '0;
      wdata_q       <= '0;
      idx           <= '0;
      tcnt          <= '0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      grant_request <= 1'b0;
      rw            <= 1'b0;
      address       <= '0;
      data_out      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (req_valid) begin
            wr_q          <= req_write;
            base_q        <= req_addr;
            wdata_q       <= req_wdata;
            idx           <= '0;
            tcnt          <= '0;
            err_q         <= 1'b0;
            resp_rdata    <= '0;
            grant_request <= 1'b1;
            rw            <= req_write;
            address       <= req_addr;
            data_out      <= req_wdata[8*BYTES-1 -: 8];
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (grant_given) begin
            if (wr_q == RW_READ) begin
              for (int k = 0; k < BYTES; k++) begin
                if (idx == IDX_W'(k)) resp_rdata[8*(BYTES-1-k) +: 8] <= data_in;
              end
            end
            grant_request <= 1'b0;
            idx           <= idx + 1'b1;
            state         <= (idx == LAST_IDX) ? ST_DONE : ST_GAP;
          end else if (TIMEOUT != 0 && tcnt == CNT_MAX) begin
            grant_request <= 1'b0;
            err_q         <= 1'b1;
            state         <= ST_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_GAP: begin
          // The wait budget restarts for every byte.
          tcnt          <= '0;
          grant_request <= 1'b1;
          address       <= base_q + ADDR_W'(idx);
          data_out      <= pick_byte(wdata_q, idx);
          state         <= ST_REQ;
        end
        ST_DONE: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_port.sv
// Bench for mem_word_port: table-driven word transfers with a bus responder
// and response scoreboard, plus reset-mid-transfer and single-byte sequences.
`timescale 1ns/1ps
module tb_mem_word_port;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        grant_request, grant_given, rw;
  logic [9:0]  address;
  logic [7:0]  data_out, data_in;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [9:0]  b_req_addr;
  logic [7:0]  b_req_wdata;
  logic        b_resp_valid, b_resp_err;
  logic [7:0]  b_resp_rdata;
  logic        b_grant_request, b_grant_given, b_rw;
  logic [9:0]  b_address;
  logic [7:0]  b_data_out, b_data_in;

  mem_word_port #(.ADDR_W(10), .BYTES(4), .TIMEOUT(4)) u_word (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .grant_request(grant_request), .grant_given(grant_given), .rw(rw),
    .address(address), .data_out(data_out), .data_in(data_in)
  );

  mem_word_port #(.ADDR_W(10), .BYTES(1)) u_byte (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_err(b_resp_err), .resp_rdata(b_resp_rdata),
    .grant_request(b_grant_request), .grant_given(b_grant_given), .rw(b_rw),
    .address(b_address), .data_out(b_data_out), .data_in(b_data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] bus;
    int          dly_byte;
    int          dly;
    int          drop_byte;
    logic        noise;
    logic        hold_valid;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int id, input vec_t v);
    int cyc, byte_i, wait_c;
    bit seen;
    exp_t e;
    logic [9:0]  ea;
    logic [31:0] snap;
    @(negedge clk);
    chk($sformatf("v%0d_req_ready", id), req_ready, 1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat});
    @(negedge clk);
    if (v.hold_valid) begin
      req_addr = v.addr ^ 10'h155; req_write = ~v.wr; req_wdata = ~v.wdata;
    end else begin
      req_valid = 1'b0;
    end
    cyc = 0; byte_i = 0; wait_c = 0; seen = 0;
    while (!seen && cyc < 64) begin
      if (resp_valid) begin
        seen = 1;
        req_valid = 1'b0; grant_given = 1'b0;
        e = sb_q.pop_front();
        chk($sformatf("v%0d_rdata", id), resp_rdata, e.rdata);
        chk($sformatf("v%0d_err", id), resp_err, e.err);
        chk($sformatf("v%0d_latency", id), cyc, e.lat);
        if (v.drop_byte < 4) begin
          chk($sformatf("v%0d_timeout_hold_cycles", id), wait_c, 4);
          chk($sformatf("v%0d_bytes_before_timeout", id), byte_i, v.drop_byte);
        end
      end else begin
        chk($sformatf("v%0d_err_without_valid", id), resp_err, 0);
        if (grant_request) begin
          if (byte_i != v.drop_byte && wait_c >= ((byte_i == v.dly_byte) ? v.dly : 0)) begin
            ea = v.addr + 10'(byte_i);
            chk($sformatf("v%0d_b%0d_address", id, byte_i), address, ea);
            chk($sformatf("v%0d_b%0d_rw", id, byte_i), rw, v.wr);
            if (v.wr) chk($sformatf("v%0d_b%0d_data_out", id, byte_i), data_out,
                          8'(v.wdata >> (8 * (3 - byte_i))));
            grant_given = 1'b1;
            data_in = v.wr ? 8'hEE : 8'(v.bus >> (8 * (3 - byte_i)));
            byte_i++; wait_c = 0;
          end else begin
            grant_given = 1'b0; data_in = 8'h00; wait_c++;
          end
        end else begin
          // Stray grants outside a request must not be taken.
          grant_given = v.noise; data_in = 8'h99;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL v%0d_resp_timeout: got no resp_valid, expected one within 64 cycles", id);
      void'(sb_q.pop_front());
      req_valid = 1'b0; grant_given = 1'b0;
    end else begin
      snap = resp_rdata;
      @(negedge clk);
      chk($sformatf("v%0d_resp_pulse_one_cycle", id), resp_valid, 0);
      chk($sformatf("v%0d_rdata_held", id), resp_rdata, snap);
      chk($sformatf("v%0d_ready_after", id), req_ready, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    vec_t post;

    vecs[0] = '{1'b0, 10'h010, 32'h0,        32'hDEADBEEF, -1, 0, 9, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 8};
    vecs[1] = '{1'b1, 10'h3FE, 32'h12345678, 32'h0,        -1, 0, 9, 1'b0, 1'b0, 32'h0,        1'b0, 8};
    vecs[2] = '{1'b0, 10'h100, 32'h0,        32'hCAFEF00D,  1, 3, 9, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 11};
    vecs[3] = '{1'b0, 10'h020, 32'h0,        32'hAABBCCDD, -1, 0, 2, 1'b0, 1'b0, 32'hAABB0000, 1'b1, 9};
    vecs[4] = '{1'b0, 10'h3FF, 32'h0,        32'h01020304, -1, 0, 9, 1'b1, 1'b1, 32'h01020304, 1'b0, 8};
    vecs[5] = '{1'b1, 10'h200, 32'hA5A55A5A, 32'h0,         3, 1, 9, 1'b1, 1'b0, 32'h0,        1'b0, 9};
    vecs[6] = '{1'b1, 10'h080, 32'h87654321, 32'h0,        -1, 0, 0, 1'b0, 1'b1, 32'h0,        1'b1, 5};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    grant_given = 1'b0; data_in = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_grant_given = 1'b0; b_data_in = '0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_grant_request", grant_request, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_address", address, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_req_ready", req_ready, 1);

    for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

    // Reset asserted between edges while byte 2 is being requested.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h040;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    for (int b = 0; b < 2; b++) begin
      grant_given = grant_request; data_in = 8'h11 * 8'(b + 1);
      @(negedge clk);
      grant_given = 1'b0;
      @(negedge clk);
    end
    chk("mid_byte2_requesting", grant_request, 1);
    chk("mid_byte2_address", address, 10'h042);
    chk("mid_partial_rdata", resp_rdata, 32'h11220000);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_grant_request", grant_request, 0);
    chk("mid_rst_address", address, 0);
    chk("mid_rst_resp_rdata", resp_rdata, 0);
    chk("mid_rst_rw", rw, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_req_ready", req_ready, 1);
    post = '{1'b0, 10'h044, 32'h0, 32'h76543210, -1, 0, 9, 1'b0, 1'b0, 32'h76543210, 1'b0, 8};
    run_txn(7, post);
    chk("sb_empty", sb_q.size(), 0);

    // Single-byte port: read then write.
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 10'h005;
    @(negedge clk);
    b_req_valid = 1'b0;
    cyc = 0;
    while (!b_resp_valid && cyc < 32) begin
      if (b_grant_request) chk("b1_rd_address", b_address, 10'h005);
      b_grant_given = b_grant_request; b_data_in = b_grant_request ? 8'h5A : 8'h00;
      @(negedge clk);
      cyc++;
    end
    b_grant_given = 1'b0;
    chk("b1_rd_latency", cyc, 2);
    chk("b1_rd_rdata", b_resp_rdata, 8'h5A);
    chk("b1_rd_err", b_resp_err, 0);

    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 10'h3FF; b_req_wdata = 8'hC3;
    @(negedge clk);
    b_req_valid = 1'b0;
    cyc = 0;
    while (!b_resp_valid && cyc < 32) begin
      if (b_grant_request) begin
        chk("b1_wr_data_out", b_data_out, 8'hC3);
        chk("b1_wr_rw", b_rw, 1);
      end
      b_grant_given = b_grant_request; b_data_in = 8'hEE;
      @(negedge clk);
      cyc++;
    end
    b_grant_given = 1'b0;
    chk("b1_wr_latency", cyc, 2);
    chk("b1_wr_rdata", b_resp_rdata, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
